// File: rtl/ifetch_multi_pkg.sv
// Shared defaults for the multi-issue instruction fetch stage.
package ifetch_multi_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INST_W  = 32;
  localparam int DEF_FETCH_W = 2;
  localparam int DEF_QDEPTH  = 8;

  // Wide enough for any practical address width; sliced to ADDR_W by users.
  localparam logic [63:0] DEF_RESET_PC = 64'd0;

endpackage

// File: rtl/ifetch_multi_fetch_queue.sv
// Fetch queue: pushes FETCH_W entries at once, pops 0..FETCH_W entries per
// cycle, flushes in one cycle and exposes the oldest FETCH_W entries.
module fetch_queue
  import ifetch_multi_pkg::*;
#(
  parameter int ENT_W   = DEF_ADDR_W + DEF_INST_W,
  parameter int FETCH_W = DEF_FETCH_W,
  parameter int QDEPTH  = DEF_QDEPTH,
  localparam int PTR_W  = $clog2(QDEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [FETCH_W*ENT_W-1:0] push_data,
  input  logic [CNT_W-1:0]         pop_cnt,
  output logic [CNT_W-1:0]         count,
  output logic [FETCH_W*ENT_W-1:0] head_data
);

  logic [ENT_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Entry storage: a whole fetch bundle lands in consecutive slots.
  // NOTE: the storage array is deliberately not reset; only pointers and
  // count are, since an entry is never read unless count says it is valid.
  always_ff @(posedge clk) begin
    if (rst && push && !flush) begin
      for (int k = 0; k < FETCH_W; k++) begin
        mem[wr_ptr + PTR_W'(k)] <= push_data[k*ENT_W +: ENT_W];
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at once.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(FETCH_W);
      end
      rd_ptr <= rd_ptr + pop_cnt[PTR_W-1:0];
      count  <= count + (push ? CNT_W'(FETCH_W) : '0) - pop_cnt;
    end
  end

  // Head window: the FETCH_W oldest slots, wrapping around the buffer.
  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      head_data[k*ENT_W +: ENT_W] = mem[rd_ptr + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/ifetch_multi.sv
// Multi-issue instruction fetch: issues FETCH_W-wide fetches under a queue
// credit rule, tracks the single in-flight bundle and redirects on branch.
module ifetch_multi
  import ifetch_multi_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                FETCH_W  = DEF_FETCH_W,
  parameter int                QDEPTH   = DEF_QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC[ADDR_W-1:0]
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      v_i,
  input  logic                      stall_i,
  input  logic                      branch_i,
  input  logic [ADDR_W-1:0]         baddr_i,
  output logic [ADDR_W-1:0]         imem_addr_o,
  input  logic [FETCH_W*INST_W-1:0] imem_inst_i,
  output logic [FETCH_W*INST_W-1:0] inst_o,
  output logic [FETCH_W*ADDR_W-1:0] origaddr_o,
  output logic [FETCH_W-1:0]        v_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        infl_addr;
  logic                     infl;
  logic                     issue;
  logic                     push;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         pop_cnt;
  logic [FETCH_W*ENT_W-1:0] push_data;
  logic [FETCH_W*ENT_W-1:0] head_data;

  assign imem_addr_o = pc;

  // Credit rule: issue only if the queue can absorb this bundle on top of
  // the one already in flight, so a push can never overflow.
  assign issue = v_i && !branch_i &&
                 (int'(count) + (infl ? FETCH_W : 0) + FETCH_W <= QDEPTH);

  // A returning bundle is dropped when a redirect arrives in the same cycle.
  assign push = infl && !branch_i;

  // Pop whatever is presented to decode, unless decode stalls or we redirect.
  assign pop_cnt = (stall_i || branch_i) ? '0 :
                   ((count > CNT_W'(FETCH_W)) ? CNT_W'(FETCH_W) : count);

  // Tag each returned lane with its own address; lane k is word addr+k.
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      push_data[k*ENT_W +: ENT_W] = {infl_addr + ADDR_W'(k),
                                     imem_inst_i[k*INST_W +: INST_W]};
    end
  end

  // PC and in-flight tracking; a redirect overrides any issue this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      infl      <= 1'b0;
      infl_addr <= '0;
    end else if (branch_i) begin
      pc   <= baddr_i;
      infl <= 1'b0;
    end else begin
      infl <= issue;
      if (issue) begin
        infl_addr <= pc;
        pc        <= pc + ADDR_W'(FETCH_W);
      end
    end
  end

  fetch_queue #(
    .ENT_W   (ENT_W),
    .FETCH_W (FETCH_W),
    .QDEPTH  (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_i),
    .push      (push),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .count     (count),
    .head_data (head_data)
  );

  // Decode view of the queue head; invalid lanes read as zero.
  always_comb begin
    v_o        = '0;
    inst_o     = '0;
    origaddr_o = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (int'(count) > k) begin
        v_o[k]                           = 1'b1;
        inst_o[k*INST_W +: INST_W]       = head_data[k*ENT_W +: INST_W];
        origaddr_o[k*ADDR_W +: ADDR_W]   = head_data[k*ENT_W + INST_W +: ADDR_W];
      end
    end
  end

endmodule

// File: tb/tb_ifetch_multi.sv
// Self-checking bench for ifetch_multi (FETCH_W=2, QDEPTH=8, RESET_PC=0).
// Reference model: pc, one optional in-flight bundle and a queue of addresses.
module tb_ifetch_multi;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int FW = 2;
  localparam int QD = 8;
  localparam int VW = AW + FW + FW*AW + FW*IW;

  logic            clk;
  logic            rst;
  logic            v_i;
  logic            stall_i;
  logic            branch_i;
  logic [AW-1:0]   baddr_i;
  logic [AW-1:0]   imem_addr_o;
  logic [FW*IW-1:0] imem_inst_i;
  logic [FW*IW-1:0] inst_o;
  logic [FW*AW-1:0] origaddr_o;
  logic [FW-1:0]   v_o;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_infl_addr;
  logic          m_infl;
  logic [AW-1:0] m_q[$];

  ifetch_multi #(
    .ADDR_W   (AW),
    .INST_W   (IW),
    .FETCH_W  (FW),
    .QDEPTH   (QD),
    .RESET_PC (32'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .v_i         (v_i),
    .stall_i     (stall_i),
    .branch_i    (branch_i),
    .baddr_i     (baddr_i),
    .imem_addr_o (imem_addr_o),
    .imem_inst_i (imem_inst_i),
    .inst_o      (inst_o),
    .origaddr_o  (origaddr_o),
    .v_o         (v_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address a is 0x1000_0000 + a.
  always @(posedge clk) begin
    imem_inst_i <= {32'h1000_0000 + imem_addr_o + 32'd1, 32'h1000_0000 + imem_addr_o};
  end

  // Expected {imem_addr_o, v_o, origaddr_o, inst_o} from the model state.
  function automatic logic [VW-1:0] model_view();
    logic [FW-1:0]    v;
    logic [FW*AW-1:0] oa;
    logic [FW*IW-1:0] in;
    v = '0; oa = '0; in = '0;
    for (int k = 0; k < FW; k++) begin
      if (k < m_q.size()) begin
        v[k]             = 1'b1;
        oa[k*AW +: AW]   = m_q[k];
        in[k*IW +: IW]   = 32'h1000_0000 + m_q[k];
      end
    end
    return {m_pc, v, oa, in};
  endfunction

  // Drive inputs mid-cycle, away from the sampling edge.
  task automatic drive(input logic r, input logic v, input logic s,
                       input logic b, input logic [AW-1:0] ba);
    @(negedge clk);
    rst = r; v_i = v; stall_i = s; branch_i = b; baddr_i = ba;
  endtask

  // Advance one clock and apply the fetch rules to the model.
  task automatic tick();
    int   n_pop;
    logic iss;
    @(posedge clk);
    if (!rst) begin
      m_pc = '0; m_infl = 1'b0; m_q.delete();
    end else if (branch_i) begin
      m_pc = baddr_i; m_infl = 1'b0; m_q.delete();
    end else begin
      iss   = v_i && ((QD - m_q.size()) - (m_infl ? FW : 0) >= FW);
      n_pop = stall_i ? 0 : ((m_q.size() < FW) ? m_q.size() : FW);
      repeat (n_pop) void'(m_q.pop_front());
      if (m_infl) begin
        for (int k = 0; k < FW; k++) m_q.push_back(m_infl_addr + AW'(k));
      end
      m_infl = iss;
      if (iss) begin
        m_infl_addr = m_pc;
        m_pc        = m_pc + AW'(FW);
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h55); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (v_o !== 2'b00 || imem_addr_o !== 32'd0 || inst_o !== '0 || origaddr_o !== '0) begin
      errors++;
      $display("FAIL reset: v_o=%b addr=%h inst=%h orig=%h, want 0", v_o, imem_addr_o, inst_o, origaddr_o);
    end
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      checks++;
      if ({imem_addr_o, v_o, origaddr_o, inst_o} !== model_view()) begin
        errors++;
        $display("FAIL stream_model c%0d: got %h want %h", i, {imem_addr_o, v_o, origaddr_o, inst_o}, model_view());
      end
      checks++;
      if (imem_addr_o !== AW'(2*i) ||
          (i >= 2 && (v_o !== 2'b11 || origaddr_o !== {AW'(2*i-3), AW'(2*i-4)} ||
                      inst_o !== {32'h1000_0000 + AW'(2*i-3), 32'h1000_0000 + AW'(2*i-4)}))) begin
        errors++;
        $display("FAIL stream_seq c%0d: addr=%0d v=%b orig=%h", i, imem_addr_o, v_o, origaddr_o);
      end
      tick();
    end
  endtask

  task automatic test_stall_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
      checks++;
      if ({imem_addr_o, v_o, origaddr_o, inst_o} !== model_view()) begin
        errors++;
        $display("FAIL fill_model c%0d: got %h want %h", i, {imem_addr_o, v_o, origaddr_o, inst_o}, model_view());
      end
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      checks++;
      if ((j == 0 && imem_addr_o !== 32'd8) || v_o !== 2'b11 ||
          origaddr_o !== {AW'(2*j+1), AW'(2*j)}) begin
        errors++;
        $display("FAIL drain_pair j%0d: addr=%0d v=%b orig=%h want pair %0d,%0d", j, imem_addr_o, v_o, origaddr_o, 2*j, 2*j+1);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, '0); tick(); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'd2); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      checks++;
      if ((i == 0 && (v_o !== 2'b00 || imem_addr_o !== 32'd2)) ||
          (i == 2 && (origaddr_o !== {32'd3, 32'd2} || inst_o !== {32'h1000_0003, 32'h1000_0002})) ||
          ({imem_addr_o, v_o, origaddr_o, inst_o} !== model_view())) begin
        errors++;
        $display("FAIL branch c%0d: addr=%h v=%b orig=%h inst=%h", i, imem_addr_o, v_o, origaddr_o, inst_o);
      end
      tick();
    end
  endtask

  task automatic test_branch_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b1, 1'b1, 1'b0, '0); tick(); end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40); tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, (i < 4), 1'b0, '0);
      checks++;
      if ((i == 0 && (v_o !== 2'b00 || imem_addr_o !== 32'h40)) ||
          (i == 3 && (v_o !== 2'b11 || origaddr_o !== {32'h41, 32'h40})) ||
          ({imem_addr_o, v_o, origaddr_o, inst_o} !== model_view())) begin
        errors++;
        $display("FAIL branch_full c%0d: addr=%h v=%b orig=%h", i, imem_addr_o, v_o, origaddr_o);
      end
      tick();
    end
  endtask

  task automatic test_vi_low();
    do_reset();
    for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, '0); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (imem_addr_o !== 32'd12 ||
          (i == 1 && (v_o !== 2'b11 || origaddr_o !== {32'd11, 32'd10})) ||
          (i == 2 && v_o !== 2'b00)) begin
        errors++;
        $display("FAIL vi_low c%0d: addr=%0d v=%b orig=%h", i, imem_addr_o, v_o, origaddr_o);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (imem_addr_o !== AW'(12 + 2*i) ||
          (i == 2 && origaddr_o !== {32'd13, 32'd12}) ||
          ({imem_addr_o, v_o, origaddr_o, inst_o} !== model_view())) begin
        errors++;
        $display("FAIL vi_resume c%0d: addr=%0d v=%b orig=%h", i, imem_addr_o, v_o, origaddr_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b1, 1'b1, 1'b0, '0); tick(); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (imem_addr_o !== AW'(2*i) || (i < 2 && v_o !== 2'b00) ||
          (i == 2 && (v_o !== 2'b11 || origaddr_o !== {32'd1, 32'd0})) ||
          ({imem_addr_o, v_o, origaddr_o, inst_o} !== model_view())) begin
        errors++;
        $display("FAIL reset_mid c%0d: addr=%0d v=%b orig=%h", i, imem_addr_o, v_o, origaddr_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic          r, v, s, b;
    logic [AW-1:0] ba;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom % 97) != 0;
      b  = ($urandom % 12) == 0;
      v  = ($urandom % 8) != 0;
      s  = ($urandom % 3) == 0;
      ba = (($urandom % 4) == 0) ? 32'hFFFF_FFFA + AW'($urandom_range(0, 5)) : AW'($urandom);
      drive(r, v, s, b, ba);
      checks++;
      if ({imem_addr_o, v_o, origaddr_o, inst_o} !== model_view()) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h", i, {imem_addr_o, v_o, origaddr_o, inst_o}, model_view());
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; v_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; baddr_i = '0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_branch();
    test_branch_full();
    test_vi_low();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
